gen_lane_packer: RTL and testbench

//  Write-side counterpart of the generic lane-select mux: collects BUS_WIDTH-bit words one per

---
 rtl/gen_lane_packer_if.sv | 52 +++++
 rtl/gen_lane_packer.sv | 111 +++++++++++
 tb/tb_gen_lane_packer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_lane_packer_if.sv
// Handshake and packed-frame bus between a lane-word source, the lane packer
// and the consumer of completed frames.
interface gen_lane_packer_if #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5
);

  localparam int N = 1 << SEL;

  logic [BUS_WIDTH-1:0]   data_in;
  logic                   data_valid;
  logic                   data_ready;
  logic                   ctrl_mode;
  logic [SEL-1:0]         ctrl_sel;
  logic                   flush;
  logic [BUS_WIDTH*N-1:0] packed_out;
  logic                   packed_valid;
  logic                   packed_ack;
  logic [N-1:0]           lane_mask;
  logic [SEL-1:0]         wr_ptr;

  // Source/consumer side: drives words, control and acknowledge.
  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    output ctrl_mode,
    output ctrl_sel,
    output flush,
    input  packed_out,
    input  packed_valid,
    output packed_ack,
    input  lane_mask,
    input  wr_ptr
  );

  // Packer side: accepts words and presents completed frames.
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    input  ctrl_mode,
    input  ctrl_sel,
    input  flush,
    output packed_out,
    output packed_valid,
    input  packed_ack,
    output lane_mask,
    output wr_ptr
  );

endinterface

// File: rtl/gen_lane_packer.sv
// Lane packer: gathers BUS_WIDTH-bit words, one per handshake, into a packed
// vector of 2**SEL lanes (lane k at packed_out[k*BUS_WIDTH +: BUS_WIDTH]).
// A frame closes when every lane has been written or when flush arrives with
// at least one lane written; it is then held until the consumer acknowledges.
module gen_lane_packer #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst,
  gen_lane_packer_if.slave    bus
);

  localparam int N = 1 << SEL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [BUS_WIDTH*N-1:0] lanes;
  logic [N-1:0]           mask;
  logic [SEL-1:0]         ptr;

  logic                   ready;
  logic                   write;
  logic                   retire;
  logic [SEL-1:0]         target;
  logic [N-1:0]           target_bit;
  logic [N-1:0]           mask_after;
  logic                   frame_close;

  // Write qualification, target lane and the mask as it will look after this edge.
  always_comb begin
    ready       = (state != DONE);
    write       = bus.data_valid & ready;
    retire      = (state == DONE) & bus.packed_ack;
    target      = bus.ctrl_mode ? bus.ctrl_sel : ptr;
    target_bit  = N'(1) << target;
    mask_after  = write ? (mask | target_bit) : mask;
    frame_close = (&mask_after) | (bus.flush & (|mask_after));
  end

  // State register; reset discards any frame in progress.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: open a frame on the first write, close it on full mask or flush, retire on ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write) begin
          state_next = frame_close ? DONE : FILL;
        end
      end
      FILL: begin
        if (frame_close) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.packed_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lane storage, written-lane mask and auto-increment pointer; all cleared when a frame retires
  // so unwritten lanes of the next frame read zero.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      lanes <= '0;
      mask  <= '0;
      ptr   <= '0;
    end else if (retire) begin
      lanes <= '0;
      mask  <= '0;
      ptr   <= '0;
    end else if (write) begin
      lanes[target*BUS_WIDTH +: BUS_WIDTH] <= bus.data_in;
      mask                                 <= mask | target_bit;
      if (!bus.ctrl_mode) begin
        ptr <= ptr + SEL'(1);
      end
    end
  end

  // Output drive: everything is register- or state-decoded, nothing flows from data_in.
  always_comb begin
    bus.data_ready   = ready;
    bus.packed_valid = (state == DONE);
    bus.packed_out   = lanes;
    bus.lane_mask    = mask;
    bus.wr_ptr       = ptr;
  end

endmodule

// File: tb/tb_gen_lane_packer.sv
// Testbench for gen_lane_packer: a 4-lane instance checked every cycle against a
// behavioural frame model plus directed literal checks, and a 32-lane instance
// exercised with a full auto-increment frame.
module tb_gen_lane_packer;

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  gen_lane_packer_if #(.BUS_WIDTH(4), .SEL(2)) small_bus ();
  gen_lane_packer_if #(.BUS_WIDTH(4), .SEL(5)) big_bus ();

  gen_lane_packer #(.BUS_WIDTH(4), .SEL(2)) dut_small (
    .i_sys_clk (clock),
    .i_sys_rst (reset),
    .bus       (small_bus.slave)
  );

  gen_lane_packer #(.BUS_WIDTH(4), .SEL(5)) dut_big (
    .i_sys_clk (clock),
    .i_sys_rst (reset),
    .bus       (big_bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs to the 4-lane instance, held across the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] data, input logic mode,
                               input logic [1:0] sel, input logic fl, input logic ack);
    small_bus.data_valid = valid;
    small_bus.data_in    = data;
    small_bus.ctrl_mode  = mode;
    small_bus.ctrl_sel   = sel;
    small_bus.flush      = fl;
    small_bus.packed_ack = ack;
    @(negedge clock);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Behavioural frame model for the 4-lane instance: a frame is a set of written lanes
  // with their values; it is closed when all lanes are written or a flush sees a
  // non-empty set, and it vanishes when the consumer acknowledges.
  logic [3:0] m_lane [4];
  bit         m_written [4];
  int         m_ptr;
  bit         m_closed;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_lane[k]    = 4'h0;
      m_written[k] = 1'b0;
    end
    m_ptr    = 0;
    m_closed = 1'b0;
  end

  always @(posedge clock) begin
    int t;
    int cnt;
    bit was_closed;
    was_closed = m_closed;
    if (reset || (m_closed && small_bus.packed_ack)) begin
      for (int k = 0; k < 4; k++) begin
        m_lane[k]    = 4'h0;
        m_written[k] = 1'b0;
      end
      m_ptr    = 0;
      m_closed = 1'b0;
    end else if (!m_closed) begin
      if (small_bus.data_valid) begin
        t = small_bus.ctrl_mode ? int'(small_bus.ctrl_sel) : m_ptr;
        m_lane[t]    = small_bus.data_in;
        m_written[t] = 1'b1;
        if (!small_bus.ctrl_mode) m_ptr = (m_ptr + 1) % 4;
      end
      cnt = 0;
      for (int k = 0; k < 4; k++) if (m_written[k]) cnt++;
      if (!was_closed && (cnt == 4 || (small_bus.flush && cnt > 0))) m_closed = 1'b1;
    end
  end

  // Every-cycle comparison of the 4-lane instance against the model, after outputs settle.
  initial begin
    logic [15:0] exp_packed;
    logic [3:0]  exp_mask;
    forever begin
      @(posedge clock);
      #2;
      if (check_en) begin
        exp_packed = '0;
        exp_mask   = '0;
        for (int k = 0; k < 4; k++) begin
          exp_packed[k*4 +: 4] = m_lane[k];
          exp_mask[k]          = m_written[k];
        end
        checkOutput("model packed_valid", small_bus.packed_valid, m_closed);
        checkOutput("model data_ready", small_bus.data_ready, !m_closed);
        checkOutput("model packed_out", small_bus.packed_out, exp_packed);
        checkOutput("model lane_mask", small_bus.lane_mask, exp_mask);
        checkOutput("model wr_ptr", small_bus.wr_ptr, m_ptr[1:0]);
      end
    end
  end

  // Directed scenarios.
  initial begin
    logic [127:0] big_expect;
    logic [31:0]  all_ones32;

    reset = 1'b1;
    small_bus.data_valid = 1'b0; small_bus.data_in = '0; small_bus.ctrl_mode = 1'b0;
    small_bus.ctrl_sel = '0; small_bus.flush = 1'b0; small_bus.packed_ack = 1'b0;
    big_bus.data_valid = 1'b0; big_bus.data_in = '0; big_bus.ctrl_mode = 1'b0;
    big_bus.ctrl_sel = '0; big_bus.flush = 1'b0; big_bus.packed_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset    = 1'b0;
    check_en = 1'b1;

    // Reset values
    checkOutput("reset packed_valid", small_bus.packed_valid, 1'b0);
    checkOutput("reset packed_out", small_bus.packed_out, 16'h0000);
    checkOutput("reset lane_mask", small_bus.lane_mask, 4'b0000);
    checkOutput("reset wr_ptr", small_bus.wr_ptr, 2'd0);
    checkOutput("reset data_ready", small_bus.data_ready, 1'b1);

    // 1: auto mode, four back-to-back writes
    applyStimulus(1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("t1 not yet valid", small_bus.packed_valid, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("t1 packed_valid", small_bus.packed_valid, 1'b1);
    checkOutput("t1 packed_out", small_bus.packed_out, 16'h4321);
    checkOutput("t1 lane_mask", small_bus.lane_mask, 4'b1111);
    checkOutput("t1 data_ready", small_bus.data_ready, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t1 ack valid", small_bus.packed_valid, 1'b0);
    checkOutput("t1 ack packed_out", small_bus.packed_out, 16'h0000);
    checkOutput("t1 ack mask", small_bus.lane_mask, 4'b0000);
    checkOutput("t1 ack ready", small_bus.data_ready, 1'b1);

    // 2: explicit lanes with a rewrite of lane 3
    applyStimulus(1'b1, 4'hA, 1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hB, 1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("t2 rewrite mask", small_bus.lane_mask, 4'b1001);
    applyStimulus(1'b1, 4'h6, 1'b1, 2'd1, 1'b0, 1'b0);
    checkOutput("t2 three lanes not valid", small_bus.packed_valid, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("t2 packed_valid", small_bus.packed_valid, 1'b1);
    checkOutput("t2 packed_out", small_bus.packed_out, 16'hB765);
    checkOutput("t2 wr_ptr unchanged", small_bus.wr_ptr, 2'd0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);

    // 3: flush alone, then write with flush in the same cycle
    applyStimulus(1'b1, 4'h9, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hC, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("t3 flush valid", small_bus.packed_valid, 1'b1);
    checkOutput("t3 flush packed_out", small_bus.packed_out, 16'h00C9);
    checkOutput("t3 flush mask", small_bus.lane_mask, 4'b0011);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hE, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("t3 write+flush valid", small_bus.packed_valid, 1'b1);
    checkOutput("t3 write+flush packed_out", small_bus.packed_out, 16'h000E);
    checkOutput("t3 write+flush mask", small_bus.lane_mask, 4'b0001);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);

    // 4: data_valid held through DONE, late ack, next frame restarts at lane 0
    applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h6, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("t4 held packed_out", small_bus.packed_out, 16'h8765);
    applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t4 ack packed_out", small_bus.packed_out, 16'h0000);
    checkOutput("t4 ack wr_ptr", small_bus.wr_ptr, 2'd0);
    applyStimulus(1'b1, 4'hD, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("t4 next frame packed_out", small_bus.packed_out, 16'h000D);
    checkOutput("t4 next frame mask", small_bus.lane_mask, 4'b0001);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Mixed modes within one frame
    applyStimulus(1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("mix wr_ptr held", small_bus.wr_ptr, 2'd1);
    applyStimulus(1'b1, 4'h3, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("mix packed_out", small_bus.packed_out, 16'h2431);
    checkOutput("mix wr_ptr", small_bus.wr_ptr, 2'd3);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);

    // 5: reset mid-frame, then flush and ack in IDLE are ignored
    applyStimulus(1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 4'h3, 1'b0, 2'd0, 1'b1, 1'b0);
    reset = 1'b0;
    checkOutput("t5 reset packed_out", small_bus.packed_out, 16'h0000);
    checkOutput("t5 reset mask", small_bus.lane_mask, 4'b0000);
    checkOutput("t5 reset wr_ptr", small_bus.wr_ptr, 2'd0);
    checkOutput("t5 reset ready", small_bus.data_ready, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("t5 idle flush ignored", small_bus.packed_valid, 1'b0);

    // 6: 32-lane instance, full auto frame with pointer wrap
    big_expect = '0;
    for (int k = 0; k < 32; k++) begin
      big_bus.data_valid = 1'b1;
      big_bus.data_in    = 4'(k);
      big_expect[k*4 +: 4] = 4'(k);
      @(negedge clock);
      if (k == 30) begin
        checkOutput("t6 wr_ptr 31", big_bus.wr_ptr, 5'd31);
        checkOutput("t6 not valid at 31", big_bus.packed_valid, 1'b0);
      end
    end
    big_bus.data_valid = 1'b0;
    all_ones32 = '1;
    checkOutput("t6 packed_valid", big_bus.packed_valid, 1'b1);
    checkOutput("t6 wr_ptr wrapped", big_bus.wr_ptr, 5'd0);
    checkOutput("t6 lane_mask", big_bus.lane_mask, all_ones32);
    checkOutput("t6 packed_out", big_bus.packed_out, big_expect);
    checkOutput("t6 data_ready", big_bus.data_ready, 1'b0);
    big_bus.packed_ack = 1'b1;
    @(negedge clock);
    big_bus.packed_ack = 1'b0;
    checkOutput("t6 ack valid", big_bus.packed_valid, 1'b0);
    checkOutput("t6 ack packed_out", big_bus.packed_out, 128'h0);
    idleCycle();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
